// File: rtl/bram_pingpong_ctrl.sv
// Ping-pong scheduler for two frame BRAMs shared by the disparity-filter writer and the frame reader.
// Tracks per-buffer ownership so a buffer is never written while read; the reader always gets the newest full frame.
module bram_pingpong_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_frame_req,
    input  logic             writer_idle,
    output logic             wr_start,
    output logic             wr_bram_index,
    input  logic             rd_req,
    input  logic             rd_done,
    output logic             rd_start,
    output logic             rd_bram_index,
    output logic [1:0]       buf0_state,
    output logic [1:0]       buf1_state,
    output logic [CNT_W-1:0] overwrite_count,
    output logic [CNT_W-1:0] skip_count
);

    typedef enum logic [1:0] {
        B_FREE    = 2'd0,
        B_WRITING = 2'd1,
        B_FULL    = 2'd2,
        B_READING = 2'd3
    } buf_e;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_LAUNCH = 2'd1,
        W_BUSY   = 2'd2
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } rstate_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    wstate_e          w_state_q, w_state_d;
    rstate_e          r_state_q, r_state_d;
    buf_e             buf_q [2];
    buf_e             buf_d [2];
    logic             newest_q, newest_d;
    logic             wr_idx_q, wr_idx_d;
    logic             rd_idx_q, rd_idx_d;
    logic             wr_start_q, wr_start_d;
    logic             rd_start_q, rd_start_d;
    logic [CNT_W-1:0] ovw_q, ovw_d;
    logic [CNT_W-1:0] skip_q, skip_d;

    logic wr_accept, wr_done, rd_avail, rd_grant, rd_release;
    logic wr_sel, rd_sel;

    assign wr_accept  = (w_state_q == W_IDLE) && wr_frame_req && writer_idle;
    assign wr_done    = (w_state_q == W_BUSY) && writer_idle;
    assign rd_avail   = (buf_q[0] == B_FULL) || (buf_q[1] == B_FULL);
    assign rd_grant   = (r_state_q == R_IDLE) && rd_req && rd_avail;
    assign rd_release = (r_state_q == R_BUSY) && rd_done;

    // Free first, then whichever buffer the reader does not hold, else the stale full one.
    always_comb begin
        wr_sel = ~newest_q;
        if (buf_q[0] == B_FREE)         wr_sel = 1'b0;
        else if (buf_q[1] == B_FREE)    wr_sel = 1'b1;
        else if (buf_q[0] == B_READING) wr_sel = 1'b1;
        else if (buf_q[1] == B_READING) wr_sel = 1'b0;
    end

    always_comb begin
        rd_sel = 1'b1;
        if ((buf_q[0] == B_FULL) && (buf_q[1] == B_FULL)) rd_sel = newest_q;
        else if (buf_q[0] == B_FULL)                        rd_sel = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            buf_q[0]   <= B_FREE;
            buf_q[1]   <= B_FREE;
            newest_q   <= 1'b0;
            wr_idx_q   <= 1'b0;
            rd_idx_q   <= 1'b0;
            wr_start_q <= 1'b0;
            rd_start_q <= 1'b0;
            ovw_q      <= '0;
            skip_q     <= '0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
            newest_q   <= newest_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            wr_start_q <= wr_start_d;
            rd_start_q <= rd_start_d;
            ovw_q      <= ovw_d;
            skip_q     <= skip_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:   if (wr_accept) w_state_d = W_LAUNCH;
            W_LAUNCH: w_state_d = W_BUSY;
            W_BUSY:   if (writer_idle) w_state_d = W_IDLE;
            default:  w_state_d = W_IDLE;
        endcase

        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (rd_grant) r_state_d = R_BUSY;
            R_BUSY:  if (rd_done) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Both FSMs act on registered buffer states; ownership exclusivity keeps their updates disjoint.
    always_comb begin
        buf_d[0]   = buf_q[0];
        buf_d[1]   = buf_q[1];
        newest_d   = newest_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        wr_start_d = 1'b0;
        rd_start_d = 1'b0;
        ovw_d      = ovw_q;
        skip_d     = skip_q;

        if (wr_accept) begin
            buf_d[wr_sel] = B_WRITING;
            wr_idx_d      = wr_sel;
            wr_start_d    = 1'b1;
            if ((buf_q[wr_sel] == B_FULL) && (ovw_q != '1)) ovw_d = ovw_q + CNT_ONE;
        end
        if (wr_frame_req && !wr_accept && (skip_q != '1)) skip_d = skip_q + CNT_ONE;
        if (wr_done) begin
            buf_d[wr_idx_q] = B_FULL;
            newest_d        = wr_idx_q;
        end
        if (rd_grant) begin
            buf_d[rd_sel] = B_READING;
            rd_idx_d      = rd_sel;
            rd_start_d    = 1'b1;
        end
        if (rd_release) buf_d[rd_idx_q] = B_FREE;
    end

    assign wr_start        = wr_start_q;
    assign wr_bram_index   = wr_idx_q;
    assign rd_start        = rd_start_q;
    assign rd_bram_index   = rd_idx_q;
    assign buf0_state      = buf_q[0];
    assign buf1_state      = buf_q[1];
    assign overwrite_count = ovw_q;
    assign skip_count      = skip_q;

endmodule

// File: tb/tb_bram_pingpong_ctrl.sv
// Scenario bench for bram_pingpong_ctrl: expected buffer indices are queued when stimulus is driven
// and popped when the DUT issues the matching start pulse. Counters use a narrow width to reach saturation.
module tb_bram_pingpong_ctrl;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_frame_req;
    logic          writer_idle;
    logic          wr_start;
    logic          wr_bram_index;
    logic          rd_req;
    logic          rd_done;
    logic          rd_start;
    logic          rd_bram_index;
    logic [1:0]    buf0_state;
    logic [1:0]    buf1_state;
    logic [CW-1:0] overwrite_count;
    logic [CW-1:0] skip_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic wr_q[$];
    logic rd_q[$];

    bram_pingpong_ctrl #(.CNT_W(CW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_frame_req   (wr_frame_req),
        .writer_idle    (writer_idle),
        .wr_start       (wr_start),
        .wr_bram_index  (wr_bram_index),
        .rd_req         (rd_req),
        .rd_done        (rd_done),
        .rd_start       (rd_start),
        .rd_bram_index  (rd_bram_index),
        .buf0_state     (buf0_state),
        .buf1_state     (buf1_state),
        .overwrite_count(overwrite_count),
        .skip_count     (skip_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        wr_frame_req = 1'b0;
        writer_idle  = 1'b1;
        rd_req       = 1'b0;
        rd_done      = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // Pulse a frame request with the writer idle; the writer then drops idle.
    task automatic launch_write();
        wr_frame_req = 1'b1;
        writer_idle  = 1'b1;
        tick();
        wr_frame_req = 1'b0;
        writer_idle  = 1'b0;
    endtask

    task automatic finish_write();
        writer_idle = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_checks++;
        if ({wr_start, wr_bram_index, rd_start, rd_bram_index, buf0_state, buf1_state} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {wr_start, wr_bram_index, rd_start, rd_bram_index, buf0_state, buf1_state});
        end
        n_checks++;
        if ({overwrite_count, skip_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_counters: got ovw=%0d skip=%0d expected 0 0", overwrite_count, skip_count);
        end
    endtask

    task automatic test_single_write();
        logic e;
        do_reset();
        wr_q.push_back(1'b0);
        launch_write();
        e = wr_q.pop_front();
        n_checks++;
        if ({wr_start, wr_bram_index, buf0_state, buf1_state} !== {1'b1, e, 2'd1, 2'd0}) begin
            n_fail++;
            $display("FAIL first_launch: got start=%b idx=%b b0=%0d b1=%0d expected 1 %b 1 0",
                     wr_start, wr_bram_index, buf0_state, buf1_state, e);
        end
        repeat (99) tick();
        n_checks++;
        if ({wr_start, buf0_state} !== {1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL long_write_hold: got start=%b b0=%0d expected 0 1", wr_start, buf0_state);
        end
        finish_write();
        n_checks++;
        if (buf0_state !== 2'd2) begin
            n_fail++;
            $display("FAIL first_complete: got b0=%0d expected 2", buf0_state);
        end
    endtask

    task automatic test_overwrite();
        logic e;
        do_reset();
        wr_q.push_back(1'b0);
        launch_write();
        repeat (5) tick();
        finish_write();
        wr_q.push_back(1'b1);
        e = wr_q.pop_front();
        n_checks++;
        if (wr_bram_index !== e) begin
            n_fail++;
            $display("FAIL ovw_frame0_idx: got %b expected %b", wr_bram_index, e);
        end
        launch_write();
        e = wr_q.pop_front();
        n_checks++;
        if ({wr_start, wr_bram_index, buf0_state, buf1_state} !== {1'b1, e, 2'd2, 2'd1}) begin
            n_fail++;
            $display("FAIL ovw_frame1: got start=%b idx=%b b0=%0d b1=%0d expected 1 %b 2 1",
                     wr_start, wr_bram_index, buf0_state, buf1_state, e);
        end
        repeat (5) tick();
        finish_write();
        n_checks++;
        if ({buf0_state, buf1_state, overwrite_count} !== {2'd2, 2'd2, 4'd0}) begin
            n_fail++;
            $display("FAIL ovw_both_full: got b0=%0d b1=%0d ovw=%0d expected 2 2 0",
                     buf0_state, buf1_state, overwrite_count);
        end
        wr_q.push_back(1'b0);
        launch_write();
        e = wr_q.pop_front();
        n_checks++;
        if ({wr_start, wr_bram_index, buf0_state, overwrite_count} !== {1'b1, e, 2'd1, 4'd1}) begin
            n_fail++;
            $display("FAIL ovw_frame2: got start=%b idx=%b b0=%0d ovw=%0d expected 1 %b 1 1",
                     wr_start, wr_bram_index, buf0_state, overwrite_count, e);
        end
        repeat (5) tick();
        finish_write();
        rd_q.push_back(1'b0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        e = rd_q.pop_front();
        n_checks++;
        if ({rd_start, rd_bram_index, buf0_state, buf1_state} !== {1'b1, e, 2'd3, 2'd2}) begin
            n_fail++;
            $display("FAIL ovw_grant_newest: got start=%b idx=%b b0=%0d b1=%0d expected 1 %b 3 2",
                     rd_start, rd_bram_index, buf0_state, buf1_state, e);
        end
    endtask

    task automatic test_read_newest();
        logic e;
        do_reset();
        launch_write();
        repeat (3) tick();
        finish_write();
        launch_write();
        repeat (3) tick();
        finish_write();
        rd_q.push_back(1'b1);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        e = rd_q.pop_front();
        n_checks++;
        if ({rd_start, rd_bram_index, buf1_state} !== {1'b1, e, 2'd3}) begin
            n_fail++;
            $display("FAIL read_grant_newest: got start=%b idx=%b b1=%0d expected 1 %b 3",
                     rd_start, rd_bram_index, buf1_state, e);
        end
        tick();
        n_checks++;
        if (rd_start !== 1'b0) begin
            n_fail++;
            $display("FAIL read_start_pulse: got %b expected 0", rd_start);
        end
        wr_q.push_back(1'b0);
        launch_write();
        e = wr_q.pop_front();
        n_checks++;
        if ({wr_start, wr_bram_index, buf0_state, buf1_state, overwrite_count} !== {1'b1, e, 2'd1, 2'd3, 4'd1}) begin
            n_fail++;
            $display("FAIL write_during_read: got start=%b idx=%b b0=%0d b1=%0d ovw=%0d expected 1 %b 1 3 1",
                     wr_start, wr_bram_index, buf0_state, buf1_state, overwrite_count, e);
        end
        repeat (3) tick();
        finish_write();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        n_checks++;
        if ({buf0_state, buf1_state} !== {2'd2, 2'd0}) begin
            n_fail++;
            $display("FAIL read_release: got b0=%0d b1=%0d expected 2 0", buf0_state, buf1_state);
        end
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        n_checks++;
        if ({rd_start, buf0_state, buf1_state} !== {1'b0, 2'd2, 2'd0}) begin
            n_fail++;
            $display("FAIL rd_done_idle_ignored: got start=%b b0=%0d b1=%0d expected 0 2 0",
                     rd_start, buf0_state, buf1_state);
        end
    endtask

    task automatic test_skip();
        logic seen;
        do_reset();
        launch_write();
        tick();
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_frame_req = 1'b1;
            tick();
            seen |= wr_start;
            wr_frame_req = 1'b0;
            tick();
            seen |= wr_start;
        end
        n_checks++;
        if ({seen, skip_count, buf0_state, buf1_state} !== {1'b0, 4'd3, 2'd1, 2'd0}) begin
            n_fail++;
            $display("FAIL skip_busy: got start_seen=%b skip=%0d b0=%0d b1=%0d expected 0 3 1 0",
                     seen, skip_count, buf0_state, buf1_state);
        end
        finish_write();
        writer_idle  = 1'b0;
        wr_frame_req = 1'b1;
        tick();
        wr_frame_req = 1'b0;
        n_checks++;
        if ({wr_start, skip_count, buf1_state} !== {1'b0, 4'd4, 2'd0}) begin
            n_fail++;
            $display("FAIL skip_writer_not_idle: got start=%b skip=%0d b1=%0d expected 0 4 0",
                     wr_start, skip_count, buf1_state);
        end
        wr_frame_req = 1'b1;
        repeat (20) tick();
        wr_frame_req = 1'b0;
        n_checks++;
        if (skip_count !== 4'd15) begin
            n_fail++;
            $display("FAIL skip_saturate: got %0d expected 15", skip_count);
        end
        writer_idle = 1'b1;
    endtask

    task automatic test_concurrent();
        logic e;
        do_reset();
        launch_write();
        repeat (3) tick();
        writer_idle = 1'b1;
        rd_req      = 1'b1;
        rd_q.push_back(1'b0);
        tick();
        n_checks++;
        if ({rd_start, buf0_state} !== {1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL complete_vs_req_same_cycle: got start=%b b0=%0d expected 0 2", rd_start, buf0_state);
        end
        tick();
        rd_req = 1'b0;
        e = rd_q.pop_front();
        n_checks++;
        if ({rd_start, rd_bram_index, buf0_state} !== {1'b1, e, 2'd3}) begin
            n_fail++;
            $display("FAIL grant_next_cycle: got start=%b idx=%b b0=%0d expected 1 %b 3",
                     rd_start, rd_bram_index, buf0_state, e);
        end
        launch_write();
        repeat (3) tick();
        finish_write();
        wr_q.push_back(1'b1);
        rd_done      = 1'b1;
        wr_frame_req = 1'b1;
        writer_idle  = 1'b1;
        tick();
        rd_done      = 1'b0;
        wr_frame_req = 1'b0;
        writer_idle  = 1'b0;
        e = wr_q.pop_front();
        n_checks++;
        if ({wr_start, wr_bram_index, buf0_state, buf1_state, overwrite_count} !== {1'b1, e, 2'd0, 2'd1, 4'd1}) begin
            n_fail++;
            $display("FAIL release_vs_launch: got start=%b idx=%b b0=%0d b1=%0d ovw=%0d expected 1 %b 0 1 1",
                     wr_start, wr_bram_index, buf0_state, buf1_state, overwrite_count, e);
        end
        tick();
        finish_write();
    endtask

    task automatic test_reset_busy();
        logic e;
        do_reset();
        launch_write();
        repeat (2) tick();
        finish_write();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        launch_write();
        tick();
        n_checks++;
        if ({wr_bram_index, buf0_state, buf1_state} !== {1'b1, 2'd3, 2'd1}) begin
            n_fail++;
            $display("FAIL pre_reset_busy: got idx=%b b0=%0d b1=%0d expected 1 3 1",
                     wr_bram_index, buf0_state, buf1_state);
        end
        reset_n     = 1'b0;
        writer_idle = 1'b1;
        tick();
        reset_n = 1'b1;
        n_checks++;
        if ({wr_start, wr_bram_index, rd_start, rd_bram_index, buf0_state, buf1_state,
             overwrite_count, skip_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got ws=%b wi=%b rs=%b ri=%b b0=%0d b1=%0d ovw=%0d skip=%0d expected all 0",
                     wr_start, wr_bram_index, rd_start, rd_bram_index, buf0_state, buf1_state,
                     overwrite_count, skip_count);
        end
        wr_q.push_back(1'b0);
        launch_write();
        e = wr_q.pop_front();
        n_checks++;
        if ({wr_start, wr_bram_index, buf0_state, buf1_state} !== {1'b1, e, 2'd1, 2'd0}) begin
            n_fail++;
            $display("FAIL post_reset_launch: got start=%b idx=%b b0=%0d b1=%0d expected 1 %b 1 0",
                     wr_start, wr_bram_index, buf0_state, buf1_state, e);
        end
        finish_write();
    endtask

    task automatic test_scoreboard_drain();
        n_checks++;
        if ((wr_q.size() + rd_q.size()) !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", wr_q.size() + rd_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_overwrite();
        test_read_newest();
        test_skip();
        test_concurrent();
        test_reset_busy();
        test_scoreboard_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
